// File: rtl/tone_gen_pkg.sv
// Shared constants for the multi-channel tone generator: note half-periods at a
// 50 MHz clock, note durations at 120 BPM, and a population-count helper.
package tone_gen_pkg;

    // Half-period in clocks = 50e6 / (2 * f_note), rounded to nearest.
    localparam logic [31:0] HP_C4 = 32'd95556;
    localparam logic [31:0] HP_D4 = 32'd85131;
    localparam logic [31:0] HP_E4 = 32'd75843;
    localparam logic [31:0] HP_F4 = 32'd71586;
    localparam logic [31:0] HP_G4 = 32'd63776;
    localparam logic [31:0] HP_A4 = 32'd56818;
    localparam logic [31:0] HP_B4 = 32'd50619;
    localparam logic [31:0] HP_C5 = 32'd47778;
    localparam logic [31:0] HP_D5 = 32'd42566;
    localparam logic [31:0] HP_E5 = 32'd37921;
    localparam logic [31:0] HP_F5 = 32'd35793;
    localparam logic [31:0] HP_G5 = 32'd31888;
    localparam logic [31:0] HP_A5 = 32'd28409;
    localparam logic [31:0] HP_B5 = 32'd25310;

    // One quarter note lasts 0.5 s at 120 BPM.
    localparam logic [31:0] DUR_WHOLE     = 32'd100000000;
    localparam logic [31:0] DUR_HALF      = 32'd50000000;
    localparam logic [31:0] DUR_QUARTER   = 32'd25000000;
    localparam logic [31:0] DUR_EIGHTH    = 32'd12500000;
    localparam logic [31:0] DUR_SIXTEENTH = 32'd6250000;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tone_ch.sv
// One tone channel: an active note (half-period counter, remaining duration)
// plus a single pending slot that is swapped in gaplessly when the note ends.
module tone_ch
    import tone_gen_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int DUR_W = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             i_load,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_half_period,
    input  logic [DUR_W-1:0] i_duration,
    output logic             o_busy,
    output logic             o_pending,
    output logic             o_done,
    output logic             o_tone
);

    logic             r_busy, r_pend, r_done, r_tone;
    logic [CNT_W-1:0] r_half, r_cnt, r_p_half;
    logic [DUR_W-1:0] r_rem, r_p_dur;

    logic             w_busy_n, w_pend_n, w_done_n, w_tone_n;
    logic [CNT_W-1:0] w_half_n, w_cnt_n, w_p_half_n;
    logic [DUR_W-1:0] w_rem_n, w_p_dur_n;
    logic             w_end, w_wrap;

    // r_rem counts down the cycles still to play, so the last busy cycle has r_rem == 1.
    assign w_end  = r_busy && (r_rem == DUR_W'(1));
    assign w_wrap = (r_half != CNT_W'(0)) && (r_cnt == (r_half - CNT_W'(1)));

    // Next-state: abort beats everything, then note end (swap/reload/idle), then play.
    always_comb begin
        w_busy_n   = r_busy;
        w_pend_n   = r_pend;
        w_done_n   = 1'b0;
        w_tone_n   = r_tone;
        w_half_n   = r_half;
        w_cnt_n    = r_cnt;
        w_rem_n    = r_rem;
        w_p_half_n = r_p_half;
        w_p_dur_n  = r_p_dur;
        if (i_abort) begin
            w_busy_n = 1'b0;
            w_pend_n = 1'b0;
            w_tone_n = 1'b0;
            w_cnt_n  = CNT_W'(0);
            w_rem_n  = DUR_W'(0);
        end else if (w_end) begin
            w_done_n = 1'b1;
            w_tone_n = 1'b0;
            w_cnt_n  = CNT_W'(0);
            if (r_pend) begin
                w_pend_n = 1'b0;
                w_half_n = r_p_half;
                w_rem_n  = r_p_dur;
            end else if (i_load) begin
                w_half_n = i_half_period;
                w_rem_n  = i_duration;
            end else begin
                w_busy_n = 1'b0;
            end
        end else if (r_busy) begin
            w_rem_n = r_rem - DUR_W'(1);
            if (r_half == CNT_W'(0)) begin
                w_cnt_n  = CNT_W'(0);
                w_tone_n = 1'b0;
            end else if (w_wrap) begin
                w_cnt_n  = CNT_W'(0);
                w_tone_n = ~r_tone;
            end else begin
                w_cnt_n = r_cnt + CNT_W'(1);
            end
            if (i_load) begin
                w_pend_n   = 1'b1;
                w_p_half_n = i_half_period;
                w_p_dur_n  = i_duration;
            end else begin
                w_pend_n = r_pend;
            end
        end else if (i_load) begin
            w_busy_n = 1'b1;
            w_half_n = i_half_period;
            w_rem_n  = i_duration;
            w_cnt_n  = CNT_W'(0);
            w_tone_n = 1'b0;
        end else begin
            w_busy_n = r_busy;
        end
    end

    // Channel state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_busy   <= 1'b0;
            r_pend   <= 1'b0;
            r_done   <= 1'b0;
            r_tone   <= 1'b0;
            r_half   <= CNT_W'(0);
            r_cnt    <= CNT_W'(0);
            r_p_half <= CNT_W'(0);
            r_rem    <= DUR_W'(0);
            r_p_dur  <= DUR_W'(0);
        end else begin
            r_busy   <= w_busy_n;
            r_pend   <= w_pend_n;
            r_done   <= w_done_n;
            r_tone   <= w_tone_n;
            r_half   <= w_half_n;
            r_cnt    <= w_cnt_n;
            r_p_half <= w_p_half_n;
            r_rem    <= w_rem_n;
            r_p_dur  <= w_p_dur_n;
        end
    end

    assign o_busy    = r_busy;
    assign o_pending = r_pend;
    assign o_done    = r_done;
    assign o_tone    = r_tone;

endmodule

// File: rtl/tone_gen_mc.sv
// Multi-channel square-wave tone generator: decodes note requests to channels,
// muxes per-channel readiness and sums the tone bits for a summing DAC.
module tone_gen_mc
    import tone_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int DUR_W  = 32,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int MIX_W = $clog2(NUM_CH + 1)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half_period,
    input  logic [DUR_W-1:0]  cfg_duration,
    output logic [NUM_CH-1:0] ch_busy,
    output logic [NUM_CH-1:0] note_done,
    output logic [NUM_CH-1:0] tone,
    output logic [MIX_W-1:0]  mix
);

    logic [NUM_CH-1:0] w_pend, w_load, w_abort;
    logic              w_ch_ok, w_is_abort, w_sel_pend, w_xfer;
    logic [MIX_W-1:0]  r_mix;

    assign w_ch_ok    = 32'(cfg_ch) < 32'(NUM_CH);
    assign w_is_abort = (cfg_duration == DUR_W'(0));

    // Pending flag of the addressed channel (0 for out-of-range channels).
    always_comb begin
        w_sel_pend = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                w_sel_pend = w_pend[i];
            end else begin
                w_sel_pend = w_sel_pend;
            end
        end
    end

    // Aborts and requests to nonexistent channels are always accepted.
    assign cfg_ready = (!w_ch_ok || w_is_abort) ? 1'b1 : !w_sel_pend;
    assign w_xfer    = cfg_valid && cfg_ready && w_ch_ok;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_load[g]  = w_xfer && !w_is_abort && (cfg_ch == CH_W'(g));
        assign w_abort[g] = w_xfer &&  w_is_abort && (cfg_ch == CH_W'(g));

        tone_ch #(
            .CNT_W (CNT_W),
            .DUR_W (DUR_W)
        ) u_tone_ch (
            .sys_clk       (sys_clk),
            .sys_rst_n     (sys_rst_n),
            .i_load        (w_load[g]),
            .i_abort       (w_abort[g]),
            .i_half_period (cfg_half_period),
            .i_duration    (cfg_duration),
            .o_busy        (ch_busy[g]),
            .o_pending     (w_pend[g]),
            .o_done        (note_done[g]),
            .o_tone        (tone[g])
        );
    end

    // Registered mix level, one cycle behind the tone bits.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mix <= MIX_W'(0);
        end else begin
            r_mix <= MIX_W'(popcount16(16'(tone)));
        end
    end

    assign mix = r_mix;

endmodule

// File: tb/tb_tone_gen_mc.sv
// Bench for tone_gen_mc: directed scenarios plus random traffic against a
// note-level reference model (tone derived from elapsed time / half-period).
module tb_tone_gen_mc;

    localparam int N = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_ch = 2'd0;
    logic [31:0] cfg_half_period = 32'd0;
    logic [31:0] cfg_duration = 32'd0;
    logic        cfg_ready;
    logic [3:0]  ch_busy, note_done, tone;
    logic [2:0]  mix;

    int n_checks = 0;
    int n_errors = 0;

    int m_busy[N], m_h[N], m_d[N], m_age[N], m_pv[N], m_ph[N], m_pd[N];
    logic [3:0] m_done;
    logic [2:0] m_mix;

    tone_gen_mc dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_ch          (cfg_ch),
        .cfg_half_period (cfg_half_period),
        .cfg_duration    (cfg_duration),
        .ch_busy         (ch_busy),
        .note_done       (note_done),
        .tone            (tone),
        .mix             (mix)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [3:0] exp_tone();
        logic [3:0] t;
        for (int i = 0; i < N; i++)
            t[i] = (m_busy[i] != 0 && m_h[i] != 0) ? (((m_age[i] / m_h[i]) % 2) == 1) : 1'b0;
        return t;
    endfunction

    function automatic logic [3:0] exp_busy();
        logic [3:0] b;
        for (int i = 0; i < N; i++) b[i] = (m_busy[i] != 0);
        return b;
    endfunction

    function automatic logic exp_ready(int ch, int d);
        return (d == 0) || (m_pv[ch] == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_h[i] = 0; m_d[i] = 0; m_age[i] = 0;
            m_pv[i] = 0; m_ph[i] = 0; m_pd[i] = 0;
        end
        m_done = 4'd0;
        m_mix = 3'd0;
    endtask

    // Advance the model across one rising edge with the inputs present before it.
    task automatic model_step(int v, int ch, int h, int d);
        logic [3:0] t;
        int  cnt;
        bit  xfer, load, abrt;
        t = exp_tone();
        cnt = 0;
        for (int i = 0; i < N; i++) cnt += t[i];
        m_mix = 3'(cnt);
        xfer = (v != 0) && exp_ready(ch, d);
        m_done = 4'd0;
        for (int i = 0; i < N; i++) begin
            load = xfer && d != 0 && ch == i;
            abrt = xfer && d == 0 && ch == i;
            if (abrt) begin
                m_busy[i] = 0; m_pv[i] = 0;
            end else if (m_busy[i] != 0 && m_age[i] + 1 == m_d[i]) begin
                m_done[i] = 1'b1;
                if (m_pv[i] != 0) begin
                    m_h[i] = m_ph[i]; m_d[i] = m_pd[i]; m_age[i] = 0; m_pv[i] = 0;
                end else if (load) begin
                    m_h[i] = h; m_d[i] = d; m_age[i] = 0;
                end else begin
                    m_busy[i] = 0;
                end
            end else if (m_busy[i] != 0) begin
                m_age[i]++;
                if (load) begin
                    m_pv[i] = 1; m_ph[i] = h; m_pd[i] = d;
                end
            end else if (load) begin
                m_busy[i] = 1; m_h[i] = h; m_d[i] = d; m_age[i] = 0;
            end
        end
    endtask

    task automatic set_in(bit v, int ch, int h, int d);
        cfg_valid = v;
        cfg_ch = 2'(ch);
        cfg_half_period = 32'(h);
        cfg_duration = 32'(d);
        #1;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_step(int'(cfg_valid), int'(cfg_ch), int'(cfg_half_period), int'(cfg_duration));
        @(negedge sys_clk);
        cfg_valid = 1'b0;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) begin
            set_in(1'b0, 0, 0, 1);
            tick();
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({ch_busy, note_done, tone, mix, cfg_ready} !== 16'h0001) begin
            n_errors++;
            $display("FAIL reset_state: got busy=%b done=%b tone=%b mix=%0d ready=%b, expected all 0 and ready=1",
                     ch_busy, note_done, tone, mix, cfg_ready);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_single_note();
        logic [11:0] pat;
        pat = 12'b111000111000;
        set_in(1'b1, 0, 3, 12);
        for (int k = 0; k < 14; k++) begin
            tick();
            n_checks++;
            if ({ch_busy, note_done, tone, mix} !== {exp_busy(), m_done, exp_tone(), m_mix}) begin
                n_errors++;
                $display("FAIL single_model k=%0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d", k,
                         ch_busy, note_done, tone, mix, exp_busy(), m_done, exp_tone(), m_mix);
            end
            n_checks++;
            if (k < 12 && {ch_busy[0], tone[0], note_done[0]} !== {1'b1, pat[k], 1'b0}) begin
                n_errors++;
                $display("FAIL single_tone k=%0d: got busy/tone/done=%b%b%b expected 1%b0", k,
                         ch_busy[0], tone[0], note_done[0], pat[k]);
            end else if (k >= 12 && {ch_busy[0], tone[0], note_done[0]} !== {2'b00, k == 12}) begin
                n_errors++;
                $display("FAIL single_end k=%0d: got busy/tone/done=%b%b%b expected 00%b", k,
                         ch_busy[0], tone[0], note_done[0], k == 12);
            end
            set_in(1'b0, 0, 0, 1);
        end
    endtask

    task automatic test_back_to_back();
        int busy_cnt, done_cnt;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            if (k == 0)      set_in(1'b1, 1, 2, 8);
            else if (k == 3) set_in(1'b1, 1, 5, 10);
            else             set_in(1'b0, 1, 3, 4);
            n_checks++;
            if (cfg_ready !== exp_ready(1, int'(cfg_duration))) begin
                n_errors++;
                $display("FAIL b2b_ready k=%0d: got %b expected %b", k, cfg_ready, exp_ready(1, int'(cfg_duration)));
            end
            tick();
            n_checks++;
            if ({ch_busy, note_done, tone, mix} !== {exp_busy(), m_done, exp_tone(), m_mix}) begin
                n_errors++;
                $display("FAIL b2b_model k=%0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d", k,
                         ch_busy, note_done, tone, mix, exp_busy(), m_done, exp_tone(), m_mix);
            end
            busy_cnt += int'(ch_busy[1]);
            done_cnt += int'(note_done[1]);
        end
        n_checks++;
        if (busy_cnt != 18 || done_cnt != 2) begin
            n_errors++;
            $display("FAIL b2b_totals: got busy=%0d done=%0d expected busy=18 done=2", busy_cnt, done_cnt);
        end
    endtask

    task automatic test_rest();
        int busy_cnt, tone_cnt;
        busy_cnt = 0; tone_cnt = 0;
        set_in(1'b1, 2, 0, 6);
        for (int k = 0; k < 10; k++) begin
            tick();
            busy_cnt += int'(ch_busy[2]);
            tone_cnt += int'(tone[2]);
            n_checks++;
            if (note_done[2] !== (k == 6)) begin
                n_errors++;
                $display("FAIL rest_done k=%0d: got %b expected %b", k, note_done[2], k == 6);
            end
            set_in(1'b0, 0, 0, 1);
        end
        n_checks++;
        if (busy_cnt != 6 || tone_cnt != 0) begin
            n_errors++;
            $display("FAIL rest_totals: got busy=%0d tone_high=%0d expected 6 and 0", busy_cnt, tone_cnt);
        end
    endtask

    task automatic test_abort();
        int done_cnt;
        done_cnt = 0;
        set_in(1'b1, 3, 4, 100);
        tick();
        idle(19);
        set_in(1'b1, 3, 0, 0);
        tick();
        n_checks++;
        if ({ch_busy[3], tone[3], note_done[3]} !== 3'b000) begin
            n_errors++;
            $display("FAIL abort_now: got busy/tone/done=%b%b%b expected 000", ch_busy[3], tone[3], note_done[3]);
        end
        for (int k = 0; k < 10; k++) begin
            idle(1);
            done_cnt += int'(note_done[3]) + int'(ch_busy[3]);
        end
        n_checks++;
        if (done_cnt != 0) begin
            n_errors++;
            $display("FAIL abort_after: got %0d busy/done cycles expected 0", done_cnt);
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 15; k++) begin
            if (k < 4)      set_in(1'b1, k, 0, 8 - k);
            else if (k < 8) set_in(1'b1, k - 4, 1, 4);
            else            set_in(1'b0, 0, 0, 1);
            tick();
            n_checks++;
            if ({ch_busy, note_done, tone, mix} !== {exp_busy(), m_done, exp_tone(), m_mix}) begin
                n_errors++;
                $display("FAIL simul_model k=%0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d", k,
                         ch_busy, note_done, tone, mix, exp_busy(), m_done, exp_tone(), m_mix);
            end
            if (k == 8 || k == 12) begin
                n_checks++;
                if (note_done !== 4'hF) begin
                    n_errors++;
                    $display("FAIL simul_done k=%0d: got %b expected 1111", k, note_done);
                end
            end
            if (k >= 10 && k <= 12) begin
                n_checks++;
                if (mix !== ((k == 11) ? 3'd0 : 3'd4)) begin
                    n_errors++;
                    $display("FAIL simul_mix k=%0d: got %0d expected %0d", k, mix, (k == 11) ? 0 : 4);
                end
            end
        end
    endtask

    task automatic test_random();
        int ch, h, d;
        bit v;
        for (int k = 0; k < 400; k++) begin
            v  = ($urandom_range(0, 9) < 4);
            ch = $urandom_range(0, 3);
            h  = $urandom_range(0, 5);
            d  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 14);
            set_in(v, ch, h, d);
            n_checks++;
            if (cfg_ready !== exp_ready(ch, d)) begin
                n_errors++;
                $display("FAIL rand_ready k=%0d: got %b expected %b", k, cfg_ready, exp_ready(ch, d));
            end
            tick();
            n_checks++;
            if ({ch_busy, note_done, tone, mix} !== {exp_busy(), m_done, exp_tone(), m_mix}) begin
                n_errors++;
                $display("FAIL rand_model k=%0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d", k,
                         ch_busy, note_done, tone, mix, exp_busy(), m_done, exp_tone(), m_mix);
            end
        end
        idle(20);
    endtask

    task automatic test_reset_mid_note();
        int done_cnt;
        done_cnt = 0;
        set_in(1'b1, 0, 1, 50);
        tick();
        idle(5);
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ch_busy, note_done, tone, mix} !== 15'd0) begin
            n_errors++;
            $display("FAIL reset_async: got busy=%b done=%b tone=%b mix=%0d expected all 0",
                     ch_busy, note_done, tone, mix);
        end
        model_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            idle(1);
            done_cnt += int'(note_done[0]) + int'(ch_busy[0]);
        end
        n_checks++;
        if (done_cnt != 0) begin
            n_errors++;
            $display("FAIL reset_after: got %0d busy/done cycles on ch0 expected 0", done_cnt);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_note();
        idle(3);
        test_back_to_back();
        idle(3);
        test_rest();
        idle(3);
        test_abort();
        idle(3);
        test_simultaneous();
        idle(3);
        test_random();
        test_reset_mid_note();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tone_gen_mc.md
TONE_GEN_MC -- requirements
Module: tone_gen_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent tone channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: half-period counter width.
REQ-003 SHALL have parameter DUR_W, default 32: note-duration counter width.
REQ-004 SHALL have port sys_clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_valid  in  1  note request valid.
REQ-007 SHALL have port cfg_ready  out  1  note request can be accepted (combinational from cfg_ch, cfg_duration, pending state).
REQ-008 SHALL have port cfg_ch  in  max(1,clog2(NUM_CH))  target channel.
REQ-009 SHALL have port cfg_half_period  in  CNT_W  clocks per tone half-period; 0 = rest (silence).
REQ-010 SHALL have port cfg_duration  in  DUR_W  note length in clocks; 0 = abort command.
REQ-011 SHALL have port ch_busy  out  NUM_CH  channel playing a note or rest.
REQ-012 SHALL have port note_done  out  NUM_CH  one-cycle pulse per completed note.
REQ-013 SHALL have port tone  out  NUM_CH  per-channel square wave.
REQ-014 SHALL have port mix  out  clog2(NUM_CH+1)  registered count of tone bits high (summing DAC input).

Function
REQ-015 Transfer SHALL occur on a cycle with cfg_valid and cfg_ready both high; no other cycle changes configuration.
REQ-016 Each channel SHALL hold one active note and one pending slot; cfg_ready = !pending[cfg_ch] when cfg_duration != 0, else 1.
REQ-017 Idle channel, transfer in cycle t: ch_busy high from t+1, counter cleared, tone 0 at t+1.
REQ-018 Busy channel, transfer: note stored in pending slot; active note unaffected.
REQ-019 While busy with half_period H>0, counter SHALL count 0..H-1 and tone SHALL toggle when counter = H-1 (toggle every H clocks; H=1 toggles every clock).
REQ-020 H=0: tone held 0, counter held 0, duration still counts.
REQ-021 Duration D: ch_busy high exactly D cycles (t+1..t+D); note_done pulses at t+D+1.
REQ-022 Note end with pending set: pending SHALL load in same cycle, ch_busy stays high, tone and counter restart at 0, note_done still pulses once (gapless).
REQ-023 Note end without pending: ch_busy falls, tone forced 0.
REQ-024 Abort (cfg_duration = 0) SHALL clear active and pending of cfg_ch next cycle, tone 0, ch_busy 0, no note_done; abort to idle channel is a no-op.
REQ-025 Channels SHALL be fully independent; simultaneous ends on several channels each pulse their own note_done.
REQ-026 mix SHALL equal popcount(tone) delayed one cycle.
REQ-027 Counter and duration arithmetic SHALL be unsigned, no wrap: D and H up to 2^W-1 valid.
REQ-028 cfg_ch >= NUM_CH: cfg_ready SHALL be 1 and transfer SHALL be ignored.

Reset
REQ-029 Reset SHALL clear all counters, active and pending slots; tone, ch_busy, note_done, mix = 0.
REQ-030 Reset mid-note SHALL silence immediately; no note_done after release.
REQ-031 First transfer SHALL be accepted on the first clock edge after reset release.

Structure
REQ-032 Shared package tone_gen_pkg SHALL hold note half-period constants for 50 MHz (C4..B5) and duration constants (1/16..whole note at 120 BPM).
REQ-033 Per-channel logic SHALL be sub-module tone_ch, instantiated NUM_CH times by generate; top holds cfg decode, ready mux and mix adder.

Verification
REQ-034 ch0 H=3 D=12 from idle -> tone 0,0,0,1,1,1,0,0,0,1,1,1; busy 12 cycles; one note_done pulse at t+13.
REQ-035 ch1 note H=2 D=8, second note H=5 D=10 sent while busy -> second accepted into pending, cfg_ready low for ch1 until swap, busy continuous 18 cycles, two note_done pulses.
REQ-036 ch2 H=0 D=6 -> tone stays 0, busy 6 cycles, note_done at t+7.
REQ-037 ch3 H=4 D=100, abort at cycle 20 -> busy and tone 0 at 21, no note_done.
REQ-038 All 4 channels H=1 D=4 started same cycle -> mix cycles 0/4, four simultaneous note_done.
REQ-039 Reset asserted mid-note on ch0 -> all outputs 0 asynchronously; no note_done after release.
